// File: rtl/imem_pkg.sv
// Shared types, default sizes and parity helper for the loadable instruction memory.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } imem_state_e;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DEPTH  = 256;
  localparam logic [DEF_DATA_W-1:0] DEF_FILL_WORD = '0;

  // Even-parity bit for words up to 64 bits; callers zero-extend, which leaves parity unchanged.
  function automatic logic even_parity(input logic [63:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/imem_loader.sv
// Program-load sequencer: RUN/LOAD/DRAIN FSM, auto-incrementing write pointer, load handshake.
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              busy,
  output imem_state_e       state,
  output logic              wr_en_c,
  output logic [ADDR_W-1:0] wr_addr_c,
  output logic [DATA_W-1:0] wr_data_c
);

  imem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              load_ready_q, load_ready_d;
  logic              busy_q, busy_d;
  logic [ADDR_W:0]   ptr_inc_c;
  logic              ptr_in_range_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      ptr_q        <= '0;
      load_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      load_ready_q <= load_ready_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    wr_en_c        = 1'b0;
    ptr_inc_c      = {1'b0, ptr_q} + (ADDR_W+1)'(1);
    ptr_in_range_c = {1'b0, ptr_q} < (ADDR_W+1)'(DEPTH);
    case (state_q)
      ST_RUN: begin
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = load_base;
        end
      end
      ST_LOAD: begin
        // Out-of-range beats are consumed (pointer advances) but never written.
        if (load_valid && load_ready_q) begin
          wr_en_c = ptr_in_range_c;
          ptr_d   = ADDR_W'(ptr_inc_c % (ADDR_W+1)'(DEPTH));
          if (load_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    load_ready_d = (state_d == ST_LOAD);
    busy_d       = (state_d != ST_RUN);
  end

  assign wr_addr_c  = ptr_q;
  assign wr_data_c  = load_data;
  assign load_ready = load_ready_q;
  assign busy       = busy_q;
  assign state      = state_q;

endmodule

// File: rtl/imem_fetch_loader.sv
// Loadable instruction memory with registered fetch port, flush/hazard control and a streaming load port.
// Optional per-word even parity is enabled by defining IMEM_PARITY_EN.
module imem_fetch_loader
  import imem_pkg::*;
#(
  parameter int unsigned       DATA_W    = DEF_DATA_W,
  parameter int unsigned       ADDR_W    = DEF_ADDR_W,
  parameter int unsigned       DEPTH     = DEF_DEPTH,
  parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(DEF_FILL_WORD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_en,
  input  logic              hazard,
  input  logic              flush,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              busy,
  output logic              parity_err
);

  imem_state_e       ld_state;
  logic              wr_en_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [DATA_W-1:0] wr_data_c;

  imem_loader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_loader (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_base  (load_base),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .busy       (busy),
    .state      (ld_state),
    .wr_en_c    (wr_en_c),
    .wr_addr_c  (wr_addr_c),
    .wr_data_c  (wr_data_c)
  );

  // Storage is never reset; contents start at FILL_WORD from elaboration.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: FILL_WORD};

  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_addr_c] <= wr_data_c;
  end

  logic              in_range_c;
  logic [DATA_W-1:0] rd_word_c;
  logic              rd_perr_c;

  assign in_range_c = {1'b0, fetch_addr} < (ADDR_W+1)'(DEPTH);
  assign rd_word_c  = in_range_c ? mem[fetch_addr] : FILL_WORD;

`ifdef IMEM_PARITY_EN
  logic par_mem [DEPTH] = '{default: even_parity(64'(FILL_WORD))};

  always_ff @(posedge clk) begin
    if (wr_en_c) par_mem[wr_addr_c] <= even_parity(64'(wr_data_c));
  end

  always_comb begin
    rd_perr_c = 1'b0;
    if (in_range_c) rd_perr_c = even_parity(64'(mem[fetch_addr])) != par_mem[fetch_addr];
  end
`else
  always_comb begin
    rd_perr_c = 1'b0;
  end
`endif

  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              perr_q, perr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q <= FILL_WORD;
      valid_q <= 1'b0;
      pc_q    <= '0;
      perr_q  <= 1'b0;
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      perr_q  <= perr_d;
    end
  end

  // Fetch priority in RUN: flush, then load_start (drops the fetch), then hazard, then fetch_en.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    if (ld_state == ST_RUN) begin
      if (flush) begin
        instr_d = FILL_WORD;
      end else if (!load_start) begin
        if (hazard) begin
          valid_d = valid_q;
          perr_d  = perr_q;
        end else if (fetch_en) begin
          instr_d = rd_word_c;
          pc_d    = fetch_addr;
          valid_d = 1'b1;
          perr_d  = rd_perr_c;
        end
      end
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign instr_pc    = pc_q;
  assign parity_err  = perr_q;

endmodule

// File: tb/tb_imem_fetch_loader.sv
// Directed bench for imem_fetch_loader with a reference memory model and an expected-result queue.
module tb_imem_fetch_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  fetch_addr;
  logic        fetch_en, hazard, flush;
  logic [31:0] instr;
  logic        instr_valid;
  logic [7:0]  instr_pc;
  logic        load_start;
  logic [7:0]  load_base;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready, busy, parity_err;

  imem_fetch_loader dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_addr  (fetch_addr),
    .fetch_en    (fetch_en),
    .hazard      (hazard),
    .flush       (flush),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_pc    (instr_pc),
    .load_start  (load_start),
    .load_base   (load_base),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .busy        (busy),
    .parity_err  (parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic [7:0]  pc;
    logic        perr;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [256];
  int          mptr;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_addr = '0; fetch_en = 0; hazard = 0; flush = 0;
    load_start = 0; load_base = '0; load_valid = 0; load_data = '0; load_last = 0;
  endtask

  task automatic push(input logic [31:0] i, input logic v, input logic [7:0] pc, input logic pe);
    exp_t e;
    e.instr = i; e.valid = v; e.pc = pc; e.perr = pe;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".instr"}, 64'(instr), 64'(e.instr));
      chk({tag, ".valid"}, 64'(instr_valid), 64'(e.valid));
      chk({tag, ".pc"}, 64'(instr_pc), 64'(e.pc));
      chk({tag, ".perr"}, 64'(parity_err), 64'(e.perr));
    end
  endtask

  task automatic fetch(input logic [7:0] a, input logic pe, input string tag);
    fetch_en = 1; fetch_addr = a;
    push(model[a], 1'b1, a, pe);
    step();
    fetch_en = 0;
    pop_check(tag);
  endtask

  task automatic load_begin(input logic [7:0] base, input logic also_fetch);
    load_start = 1; load_base = base; fetch_en = also_fetch; fetch_addr = 8'h10;
    step();
    load_start = 0; fetch_en = 0;
    mptr = int'(base);
    chk("load_start_busy", 64'(busy), 64'd1);
    chk("load_start_ready", 64'(load_ready), 64'd1);
    chk("load_start_drops_fetch", 64'(instr_valid), 64'd0);
  endtask

  // Fetch is held requested during the beat to confirm it is ignored while loading.
  task automatic load_beat(input logic [31:0] d, input logic last);
    chk("beat_ready", 64'(load_ready), 64'd1);
    load_valid = 1; load_data = d; load_last = last;
    fetch_en = 1; fetch_addr = 8'(mptr);
    step();
    model[mptr] = d;
    mptr = (mptr + 1) % 256;
    load_valid = 0; load_last = 0; fetch_en = 0;
    chk("load_valid_low", 64'(instr_valid), 64'd0);
    chk("beat_busy", 64'(busy), 64'd1);
  endtask

  logic [31:0] held_instr;

  initial begin
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
    idle_inputs();
    rst = 0;

    // Reset with random inputs.
    for (int i = 0; i < 4; i++) begin
      fetch_addr = 8'($urandom); fetch_en = 1'($urandom); hazard = 1'($urandom);
      flush = 1'($urandom); load_start = 1'($urandom); load_base = 8'($urandom);
      load_valid = 1'($urandom); load_data = $urandom; load_last = 1'($urandom);
      step();
      chk("rst_instr", 64'(instr), 64'h0);
      chk("rst_valid", 64'(instr_valid), 64'd0);
      chk("rst_pc", 64'(instr_pc), 64'd0);
      chk("rst_ready", 64'(load_ready), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_perr", 64'(parity_err), 64'd0);
    end
    idle_inputs();
    rst = 1;
    step();
    chk("post_rst_busy", 64'(busy), 64'd0);

    // Three-beat load at 0x10, then fetch.
    load_begin(8'h10, 1'b0);
    load_beat(32'hAAAA0001, 1'b0);
    load_beat(32'hAAAA0002, 1'b0);
    load_beat(32'hAAAA0003, 1'b1);
    chk("drain_ready", 64'(load_ready), 64'd0);
    step();
    chk("drain_done_busy", 64'(busy), 64'd0);
    fetch(8'h11, 1'b0, "fetch_11");
    chk("fetch_11_literal", 64'(instr), 64'hAAAA0002);
    fetch(8'h10, 1'b0, "fetch_10");
    fetch(8'h12, 1'b0, "fetch_12");

    // Wrap-around load with a simultaneous fetch request on load_start.
    load_begin(8'hFF, 1'b1);
    load_beat(32'h11111111, 1'b0);
    load_beat(32'h22222222, 1'b1);
    step();
    chk("wrap_drain_busy", 64'(busy), 64'd0);

    // Back-to-back load, interrupted by reset after 2 of 4 beats.
    load_begin(8'h40, 1'b0);
    load_beat(32'h55550000, 1'b0);
    load_beat(32'h55550001, 1'b0);
    rst = 0;
    #1;
    chk("midload_rst_busy", 64'(busy), 64'd0);
    chk("midload_rst_ready", 64'(load_ready), 64'd0);
    step();
    rst = 1;
    step();
    fetch(8'hFF, 1'b0, "wrap_ff");
    chk("wrap_ff_literal", 64'(instr), 64'h11111111);
    fetch(8'h00, 1'b0, "wrap_00");
    chk("wrap_00_literal", 64'(instr), 64'h22222222);
    fetch(8'h40, 1'b0, "partial_40");
    fetch(8'h41, 1'b0, "partial_41");
    fetch(8'h42, 1'b0, "partial_42");
    chk("partial_42_fill", 64'(instr), 64'h0);
    fetch(8'h43, 1'b0, "partial_43");

    // Hazard freezes outputs while fetch_addr moves.
    fetch(8'h12, 1'b0, "pre_hazard");
    held_instr = model[8'h12];
    for (int i = 0; i < 3; i++) begin
      hazard = 1; fetch_en = 1; fetch_addr = 8'(8'h10 + i);
      push(held_instr, 1'b1, 8'h12, 1'b0);
      step();
      pop_check("hazard_hold");
    end
    // Flush wins over hazard: fill word, invalid, pc held.
    flush = 1;
    push(32'h0, 1'b0, 8'h12, 1'b0);
    step();
    flush = 0; hazard = 0; fetch_en = 0;
    pop_check("flush_over_hazard");
    // Idle after a fetch: valid drops, word and pc hold.
    fetch(8'h11, 1'b0, "pre_idle");
    push(32'hAAAA0002, 1'b0, 8'h11, 1'b0);
    step();
    pop_check("idle_hold");

`ifdef IMEM_PARITY_EN
    dut.par_mem[8'h40] = ~dut.par_mem[8'h40];
    fetch(8'h40, 1'b1, "parity_bad");
    fetch(8'h41, 1'b0, "parity_clean");
`endif

    idle_inputs();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/imem_fetch_loader.md
Name: imem_fetch_loader

Overview:
- Parametrised, loadable instruction memory with a registered fetch port, replacing the fixed 256x32 ROM.
- Adds a streaming program-load port with valid/ready handshake and auto-incrementing write pointer.
- Adds explicit instr_valid/instr_pc qualifiers plus flush and hazard-hold semantics.
- Sits between the PC/fetch stage and IF/ID register.

Parameters:
- DATA_W, 32, instruction word width.
- ADDR_W, 8, fetch/load address width.
- DEPTH, 256, number of words; must be <= 2**ADDR_W.
- FILL_WORD, 0, power-up content of every word; also returned for out-of-range fetch and after flush.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- fetch_addr  in  ADDR_W  word address to fetch.
- fetch_en  in  1  fetch request.
- hazard  in  1  pipeline stall; holds all fetch outputs.
- flush  in  1  kill the word in flight.
- instr  out  DATA_W  fetched word.
- instr_valid  out  1  instr is a live fetch result.
- instr_pc  out  ADDR_W  address that produced instr.
- load_start  in  1  begin program load (sampled in RUN only).
- load_base  in  ADDR_W  first write address, sampled with load_start.
- load_valid  in  1  load_data valid.
- load_data  in  DATA_W  word to write.
- load_last  in  1  qualifies final word of load burst.
- load_ready  out  1  block accepts load_data.
- busy  out  1  high in LOAD or DRAIN.
- parity_err  out  1  read parity mismatch (see Optional Feature).

Behaviour:
- Reset (rst=0, async):
  - state=RUN, instr=FILL_WORD, instr_valid=0, instr_pc=0.
  - load_ready=0, busy=0, parity_err=0, write pointer=0.
  - Memory array is not reset; initialised to FILL_WORD at elaboration only.
- FSM states:
  - RUN -> LOAD on load_start.
  - LOAD -> DRAIN on accepted beat with load_last=1.
  - DRAIN -> RUN unconditionally after 1 cycle.
- RUN fetch, priority flush > hazard > fetch_en:
  - flush: next cycle instr=FILL_WORD, instr_valid=0; instr_pc holds.
  - hazard (no flush): instr, instr_valid, instr_pc hold.
  - fetch_en: latency 1 cycle. instr=mem[fetch_addr], instr_pc=fetch_addr, instr_valid=1.
  - Idle (none of the above): instr_valid=0; instr and instr_pc hold.
- Out-of-range fetch (fetch_addr >= DEPTH): instr=FILL_WORD, instr_valid=1.
- load_start while in RUN:
  - Takes effect even if fetch_en is also asserted; the fetch is dropped.
  - pointer<=load_base, instr_valid<=0.
- LOAD:
  - load_ready=1.
  - Beat accepted when load_valid & load_ready: mem[pointer]<=load_data, pointer<=(pointer+1) mod DEPTH.
  - Writes with pointer >= DEPTH are discarded, but the pointer still increments.
  - load_last without load_valid is ignored.
- LOAD/DRAIN:
  - fetch_en, hazard, flush and load_start ignored; instr_valid=0; instr holds.
  - busy=1. load_ready=0 in DRAIN.
- DRAIN: one bubble cycle guarantees first post-load fetch sees written data; no read-during-write hazard exists.
- Reset mid-load: immediate return to RUN. Words already written are retained; the remainder is unchanged.
- Back-to-back load: load_start is accepted in the first RUN cycle after DRAIN.

Optional Feature:
- IMEM_PARITY_EN defined:
  - Each word carries one extra even-parity bit, computed on write, including FILL_WORD at init.
  - On each fetch, parity_err=1 for exactly the cycles instr_valid=1 with mismatched parity; it holds with hazard.
  - Out-of-range fetch: parity_err=0.
- IMEM_PARITY_EN undefined: no parity storage; parity_err tied 0. The port list is identical in both builds.

Decomposition:
- Package imem_pkg:
  - State enum (RUN, LOAD, DRAIN).
  - Default DATA_W/ADDR_W/DEPTH constants.
  - FILL_WORD default.
  - Parity function.
- Sub-module imem_loader: FSM, write pointer, load_ready, busy. It outputs a write enable, address and data to the top, which owns the array and fetch register.

Test Plan:
- Reset: hold rst=0 with random inputs -> instr=0, instr_valid=0, instr_pc=0, load_ready=0, busy=0. Release rst -> RUN.
- Load and fetch:
  - load_start with load_base=0x10, beats 0xAAAA0001/0xAAAA0002/0xAAAA0003 (last on third) -> load_ready high 3+ cycles, busy drops 1 cycle after last beat.
  - Then fetch 0x11 -> next cycle instr=0xAAAA0002, instr_pc=0x11, instr_valid=1.
- Wrap-around: load_base=0xFF with two beats 0x11111111, 0x22222222 -> mem[0xFF]=0x11111111, mem[0x00]=0x22222222, verified by fetch.
- Hazard/flush:
  - Fetch 0x00, then hazard=1 for 3 cycles while fetch_addr changes -> outputs frozen.
  - hazard=1 with flush=1 -> instr=FILL_WORD, instr_valid=0 next cycle.
- Reset mid-load: assert rst=0 after 2 of 4 beats -> busy=0 immediately. Fetch shows the 2 written words; untouched words read FILL_WORD.
- IMEM_PARITY_EN: force a single-bit flip in a stored word via backdoor, then fetch it -> parity_err=1 for one cycle with instr_valid=1. Clean word -> parity_err=0.
